// File: rtl/dram_uart_pkg.sv
// Shared definitions for the DRAM read-word UART logger.
//   tx_state_e      : serialiser FSM states
//   UART_DATA_BITS  : data bits per 8N1 character
//   BYTES_PER_WORD  : characters sent per buffered read word
//   calc_baud_div() : clock cycles per UART bit (truncating divide)
package dram_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 2;

  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/dram_rd_uart_tx_sync_fifo.sv
// Single-clock word FIFO used to decouple the DRAM read sequencer from the
// much slower UART serialiser.
//   clk, rst_n : core clock, asynchronous active-low reset
//   push       : write wr_data this cycle (ignored when full)
//   pop        : drop the head word this cycle (ignored when empty)
//   wr_data    : word to write
//   rd_data    : current head word (valid while !empty)
//   full/empty : derived from the level counter
//   level      : number of words currently held (0..DEPTH)
module sync_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only the pointers and the level
  // counter define which entries are meaningful, so resetting data buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dram_rd_uart_tx.sv
// Buffers 16-bit DRAM read words and serialises each one onto uart_txd as two
// 8N1 characters, high byte first, so a host can log every read word.
//   clk, rst_n : core clock, asynchronous active-low reset
//   rd_data    : DRAM read word
//   rd_valid   : rd_data valid this cycle
//   rd_ready   : FIFO can accept a word
//   ovf_clr    : clears the sticky overflow flag
//   overflow   : sticky, a word arrived while rd_ready was low
//   fifo_level : words currently buffered
//   tx_busy    : serialiser active or words pending
//   word_sent  : one-cycle pulse as the second stop bit of a word ends
//   uart_txd   : registered serial output, idles high
module dram_rd_uart_tx
  import dram_uart_pkg::*;
#(
  parameter  int CLK_HZ     = 200_000_000,
  parameter  int BAUD       = 115200,
  parameter  int FIFO_DEPTH = 16,
  parameter  int DW         = 16,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] rd_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic          ovf_clr,
  output logic          overflow,
  output logic [LW-1:0] fifo_level,
  output logic          tx_busy,
  output logic          word_sent,
  output logic          uart_txd
);

  localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
  localparam int BCW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  tx_state_e      state;
  logic [BCW-1:0] baud_cnt;
  logic [2:0]     bit_cnt;
  logic [DW-1:0]  hold;
  logic           byte_sel;
  logic           done_q;

  logic           fifo_full;
  logic           fifo_empty;
  logic [DW-1:0]  fifo_head;
  logic           pop;
  logic           baud_end;
  logic           word_end;
  logic [7:0]     cur_byte;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rd_valid),
    .pop     (pop),
    .wr_data (rd_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign rd_ready = !fifo_full;
  assign tx_busy  = (state != IDLE) || !fifo_empty;
  assign baud_end = (baud_cnt == BCW'(BAUD_DIV - 1));

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    word_end = 1'b0;
    pop      = 1'b0;
    cur_byte = hold[15:8];
    if (byte_sel) cur_byte = hold[7:0];
    if (state == STOP && baud_end && byte_sel == 1'(BYTES_PER_WORD - 1))
      word_end = 1'b1;
    // Pop when leaving IDLE, or at the end of a word so the next word follows
    // with no idle gap.
    if (!fifo_empty && (state == IDLE || word_end))
      pop = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      byte_sel  <= 1'b0;
      done_q    <= 1'b0;
      word_sent <= 1'b0;
      uart_txd  <= 1'b1;
    end else begin
      // The line level is a registered copy of the current state, so each
      // bit lasts exactly BAUD_DIV cycles, one cycle behind the FSM.
      case (state)
        START:   uart_txd <= 1'b0;
        DATA:    uart_txd <= cur_byte[bit_cnt];
        default: uart_txd <= 1'b1;
      endcase

      // Two-stage pulse lines word_sent up with the end of the visible stop
      // bit rather than the end of the FSM STOP state.
      done_q    <= word_end;
      word_sent <= done_q;

      if (state == IDLE || baud_end) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            hold     <= fifo_head;
            byte_sel <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_cnt == 3'(UART_DATA_BITS - 1)) state <= STOP;
            else                                   bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              state    <= START;
            end else if (!fifo_empty) begin
              hold     <= fifo_head;
              byte_sel <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new overflow in the same cycle as ovf_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    overflow <= 1'b0;
    else if (rd_valid && !rd_ready) overflow <= 1'b1;
    else if (ovf_clr)              overflow <= 1'b0;
  end

endmodule

// File: tb/tb_dram_rd_uart_tx.sv
// Self-checking bench for dram_rd_uart_tx at CLK_HZ=1 MHz, BAUD=100 kbaud
// (10 cycles per bit) with a 4-word FIFO. A UART receiver model decodes the
// line and compares each byte against a queue filled when words are pushed.
module tb_dram_rd_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          ovf_clr;
  logic          overflow;
  logic [LW-1:0] fifo_level;
  logic          tx_busy;
  logic          word_sent;
  logic          uart_txd;

  dram_rd_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH),
    .DW         (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .tx_busy    (tx_busy),
    .word_sent  (word_sent),
    .uart_txd   (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         ws_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // UART receiver model: samples mid-bit on negedges.
  bit         prev_txd   = 1'b1;
  bit         mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_sh;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (prev_txd && uart_txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 5) begin
        check("rx_start_bit", uart_txd, 1'b0);
      end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
        mon_sh = {uart_txd, mon_sh[7:1]};
      end else if (mon_cnt == 95) begin
        check("rx_stop_bit", uart_txd, 1'b1);
        if (exp_q.size() == 0) check("rx_unexpected_byte", {24'h0, mon_sh}, 32'hFFFF_FFFF);
        else                   check("rx_byte", mon_sh, exp_q.pop_front());
        mon_active = 1'b0;
      end
    end
    prev_txd = (uart_txd !== 1'b0);
  end

  always @(negedge clk) if (word_sent === 1'b1) ws_q.push_back(cyc);

  // Drives one word for one edge; returns the cycle stamp of the push edge.
  task automatic push_word(input logic [15:0] w, input bit expect_tx, output int p);
    rd_data  = w;
    rd_valid = 1'b1;
    if (expect_tx) begin
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    @(negedge clk);
    p        = cyc;
    rd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (n < max_cycles && (exp_q.size() != 0 || tx_busy !== 1'b0)) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", (n < max_cycles), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_logs();
    start_q.delete();
    ws_q.delete();
  endtask

  typedef struct {
    logic        valid;
    logic        clr;
    logic [15:0] data;
    logic        acc;
    int          level;
    logic        ready;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int p, s0, gaps, lows;
    vec_t v;

    rd_data  = '0;
    rd_valid = 1'b0;
    ovf_clr  = 1'b0;
    rst_n    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_ready", rd_ready, 1'b1);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_word_sent", word_sent, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word: latency and frame length
    clear_logs();
    push_word(16'hA5A5, 1'b1, p);
    check("single_level_after_push", fifo_level, 1);
    check("single_txd_push_edge", uart_txd, 1'b1);
    @(negedge clk);
    check("single_level_after_pop", fifo_level, 0);
    check("single_txd_pop_edge", uart_txd, 1'b1);
    check("single_busy", tx_busy, 1'b1);
    @(negedge clk);
    check("single_txd_low_2cyc", uart_txd, 1'b0);
    wait_drain(600);
    check("single_frames", start_q.size(), 2);
    check("single_start_cycle", start_q[0] - p, 2);
    check("single_no_gap", start_q[1] - start_q[0], 100);
    check("single_ws_count", ws_q.size(), 1);
    check("single_ws_time", ws_q[0] - start_q[0], 200);

    // Back-to-back words
    clear_logs();
    rd_data  = 16'h1234;
    rd_valid = 1'b1;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    @(negedge clk);
    rd_data = 16'hBEEF;
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    @(negedge clk);
    rd_valid = 1'b0;
    check("b2b_level_push_pop", fifo_level, 1);
    wait_drain(1000);
    check("b2b_frames", start_q.size(), 4);
    gaps = 0;
    for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 100) gaps++;
    check("b2b_no_idle_gaps", gaps, 0);
    check("b2b_ws_count", ws_q.size(), 2);
    check("b2b_ws_first", ws_q[0] - start_q[0], 200);
    check("b2b_ws_spacing", ws_q[1] - ws_q[0], 200);

    // Full / overflow, table driven while word 0 is on the line
    clear_logs();
    vecs = '{
      '{1'b1, 1'b0, 16'h1111, 1'b1, 1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 16'h2222, 1'b1, 2, 1'b1, 1'b0},
      '{1'b1, 1'b0, 16'h3333, 1'b1, 3, 1'b1, 1'b0},
      '{1'b1, 1'b0, 16'h4444, 1'b1, 4, 1'b0, 1'b0},
      '{1'b1, 1'b0, 16'hDEAD, 1'b0, 4, 1'b0, 1'b1},
      '{1'b0, 1'b1, 16'h0000, 1'b0, 4, 1'b0, 1'b0},
      '{1'b1, 1'b1, 16'hBAD1, 1'b0, 4, 1'b0, 1'b1},
      '{1'b0, 1'b1, 16'h0000, 1'b0, 4, 1'b0, 1'b0},
      '{1'b0, 1'b0, 16'hFFFF, 1'b0, 4, 1'b0, 1'b0}
    };
    push_word(16'h0102, 1'b1, p);
    s0 = p + 2;
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      v        = vecs[i];
      rd_valid = v.valid;
      ovf_clr  = v.clr;
      rd_data  = v.data;
      if (v.acc) begin
        exp_q.push_back(v.data[15:8]);
        exp_q.push_back(v.data[7:0]);
      end
      @(negedge clk);
      check($sformatf("vec%0d_level", i), fifo_level, v.level);
      check($sformatf("vec%0d_ready", i), rd_ready, v.ready);
      check($sformatf("vec%0d_ovf", i), overflow, v.ovf);
    end
    rd_valid = 1'b0;
    ovf_clr  = 1'b0;

    // Push held across the pop that frees a slot at full
    while (cyc < s0 + 197) @(negedge clk);
    rd_data  = 16'h6666;
    rd_valid = 1'b1;
    @(negedge clk);
    check("full_pop_pre_level", fifo_level, 4);
    check("full_pop_pre_ready", rd_ready, 1'b0);
    @(negedge clk);
    check("full_pop_level", fifo_level, 3);
    check("full_pop_ready_next", rd_ready, 1'b1);
    check("full_pop_ovf", overflow, 1'b1);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h66);
    @(negedge clk);
    rd_valid = 1'b0;
    check("full_refill_level", fifo_level, 4);
    check("full_refill_ready", rd_ready, 1'b0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    wait_drain(2000);
    check("full_frames", start_q.size(), 12);
    gaps = 0;
    for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 100) gaps++;
    check("full_no_idle_gaps", gaps, 0);
    check("full_ws_count", ws_q.size(), 6);

    // Reset in the middle of byte 0 data bits (bit 5 of 0x0F is low)
    clear_logs();
    push_word(16'h0F0F, 1'b0, p);
    while (cyc < p + 2 + 63) @(negedge clk);
    check("midrst_pre_txd", uart_txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_txd_now", uart_txd, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_level", fifo_level, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("midrst_line_idle", lows, 0);
    check("midrst_no_word_sent", ws_q.size(), 0);
    check("midrst_one_partial_frame", start_q.size(), 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
